// File: rtl/bus_rcv_if.sv
// bus_rcv_if: receive-side bus bundle between the bus/strobe producer and
// the bus_rcv capture FIFO. The master drives the bus word and strobes; the
// slave (bus_rcv) returns the FIFO head and status.
interface bus_rcv_if #(
    parameter int n = 4
);
    logic [n-1:0] B;     // shared bus value
    logic         L;     // load strobe
    logic         R;     // pop head entry
    logic         Clr;   // clear sticky overflow
    logic [n-1:0] Q;     // FWFT head, 0 when empty
    logic         V;     // head valid
    logic         Full;  // all entries occupied
    logic         Ovf;   // sticky dropped-load flag

    modport master (output B, L, R, Clr, input Q, V, Full, Ovf);
    modport slave  (input B, L, R, Clr, output Q, V, Full, Ovf);
endinterface

// File: rtl/bus_rcv.sv
// bus_rcv: receiving end of the shared tri-state bus. Captures B on L into a
// DEPTH-entry first-word-fall-through FIFO, popped by R. Reports V/Full and a
// sticky Ovf for loads dropped while full.
// Optional feature macro: RCV_CAPTURE_COUNT_EN adds Cnt[7:0], a wrapping
// count of accepted pushes.
module bus_rcv #(
    parameter int n     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    bus_rcv_if.slave   bus
`ifdef RCV_CAPTURE_COUNT_EN
    ,
    output logic [7:0] Cnt
`endif
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [n-1:0]  mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0]   cnt;
    logic          v, full;
    logic          push, pop, drop;

    assign v    = (cnt != '0);
    assign full = (cnt == FULL_CNT);

    // A pop frees a slot this edge, so a load while full is still taken if R
    // pops at the same time. Pop on empty is ignored, which also means L+R on
    // empty degenerates to a plain push.
    assign pop  = bus.R && v;
    assign push = bus.L && (!full || pop);
    assign drop = bus.L && full && !pop;

    // Storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr] <= bus.B;
    end

    // Pointers and occupancy; Rst discards everything held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + PTR_ONE;
            if (pop)  rd <= rd + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as Clr leaves the flag set.
    always_ff @(posedge Clk) begin
        if (Rst)
            bus.Ovf <= 1'b0;
        else if (drop)
            bus.Ovf <= 1'b1;
        else if (bus.Clr)
            bus.Ovf <= 1'b0;
    end

`ifdef RCV_CAPTURE_COUNT_EN
    // Accepted-push counter; wraps naturally at 8 bits, ignores Clr.
    always_ff @(posedge Clk) begin
        if (Rst)
            Cnt <= '0;
        else if (push)
            Cnt <= Cnt + 8'd1;
    end
`endif

    // Outputs depend only on registered state, never on B/L/R directly.
    assign bus.Q    = v ? mem[rd] : '0;
    assign bus.V    = v;
    assign bus.Full = full;
endmodule
